// File: rtl/dlf_pkg.sv
// Shared types and arithmetic helpers for the serial IIR loop filter.
// Helpers work on a 64-bit signed carrier; callers size-cast the result.
package dlf_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_UPD  = 2'd2
  } state_e;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t coef_one(input int frac);
    return wide_t'(1) <<< frac;
  endfunction

  // Coefficient address map: b_k sits at k, a_k at order+k.
  function automatic int b_idx(input int k);
    return k;
  endfunction

  function automatic int a_idx(input int k, input int order);
    return order + k;
  endfunction

  function automatic wide_t round_half_up(input wide_t a, input int frac);
    wide_t half;
    half = wide_t'(1) <<< (frac - 1);
    return (a + half) >>> frac;
  endfunction

  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t to_offset(input wide_t y, input int w);
    return y ^ (wide_t'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dlf_coef_bank.sv
// Two banks of 2*ORDER+1 coefficients; reset to pass-through (b0 = 1.0).
// Writes to the bank the datapath is using are refused while it is busy.
module dlf_coef_bank
  import dlf_pkg::*;
#(
  parameter int COEF_W    = 20,
  parameter int COEF_FRAC = 18,
  parameter int ORDER     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [2:0]        waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic              busy_i,
  input  logic              active_bank_i,
  output logic              err_o,
  input  logic              rbank_i,
  input  logic [2:0]        ridx_i,
  output logic [COEF_W-1:0] rdata_o
);

  localparam int NC = 2 * ORDER + 1;
  localparam logic [COEF_W-1:0] ONE = COEF_W'(coef_one(COEF_FRAC));

  logic [COEF_W-1:0] coef_q [2][NC];
  logic              err_q;
  logic              addr_ok;
  logic              wr_ok;

  assign addr_ok = (waddr_i <= 3'(NC - 1));
  assign wr_ok   = we_i && addr_ok && !(busy_i && (wbank_i == active_bank_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NC; i++) begin
          coef_q[b][i] <= (i == 0) ? ONE : '0;
        end
      end
      err_q <= 1'b0;
    end else begin
      err_q <= we_i && !wr_ok;
      if (wr_ok) coef_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  assign err_o   = err_q;
  assign rdata_o = coef_q[rbank_i][ridx_i];

endmodule

// File: rtl/dlf_iir_serial.sv
// Time-multiplexed IIR loop filter: one MAC walks b0..bN then a1..aN per sample,
// then rounds, saturates and emits an offset-binary DCO code.
module dlf_iir_serial
  import dlf_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 10,
  parameter int COEF_W    = 20,
  parameter int COEF_FRAC = 18,
  parameter int ORDER     = 3,
  parameter int ACC_W     = OUT_W + COEF_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_mag,
  input  logic              in_lead,
  input  logic              bank_sel,
  input  logic              hold,
  input  logic              flush,
  input  logic              coef_we,
  input  logic              coef_bank,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_err,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_code,
  output logic              sat_flag
);

  localparam int NC = 2 * ORDER + 1;
  localparam int PW = OUT_W + COEF_W;
  localparam logic [OUT_W-1:0] CODE_MID = {1'b1, {(OUT_W-1){1'b0}}};

  state_e                   state_q;
  logic [2:0]               k_q;
  logic                     bank_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [IN_W:0]     x_hist_q [ORDER+1];
  logic signed [OUT_W-1:0]  y_hist_q [1:ORDER];
  logic [OUT_W-1:0]         out_code_q;
  logic                     out_valid_q;
  logic                     sat_q;
  logic                     flush_pend_q;

  logic signed [IN_W:0]     mag_s;
  logic signed [IN_W:0]     x_in;
  logic [COEF_W-1:0]        coef;
  logic signed [OUT_W-1:0]  op;
  logic                     neg;
  logic signed [PW-1:0]     op_ext;
  logic signed [PW-1:0]     coef_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_d;
  wide_t                    v_d;
  wide_t                    y_w;
  logic signed [OUT_W-1:0]  y_d;
  logic [OUT_W-1:0]         code_d;
  logic                     sat_d;

  assign mag_s    = $signed({1'b0, in_mag});
  assign x_in     = in_lead ? mag_s : -mag_s;
  assign in_ready = (state_q == S_IDLE) && !hold && !flush && !flush_pend_q && !rst;

  dlf_coef_bank #(
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ORDER     (ORDER)
  ) u_coef (
    .clk           (clk),
    .rst           (rst),
    .we_i          (coef_we),
    .wbank_i       (coef_bank),
    .waddr_i       (coef_addr),
    .wdata_i       (coef_wdata),
    .busy_i        (state_q != S_IDLE),
    .active_bank_i (bank_q),
    .err_o         (coef_err),
    .rbank_i       (bank_q),
    .ridx_i        (k_q),
    .rdata_o       (coef)
  );

  // Coefficient index equals k, so only the history operand needs muxing.
  always_comb begin
    op  = '0;
    neg = 1'b0;
    for (int i = 0; i <= ORDER; i++) begin
      if (k_q == 3'(b_idx(i))) op = OUT_W'(x_hist_q[i]);
    end
    for (int i = 1; i <= ORDER; i++) begin
      if (k_q == 3'(a_idx(i, ORDER))) begin
        op  = y_hist_q[i];
        neg = 1'b1;
      end
    end
  end

  assign op_ext   = {{COEF_W{op[OUT_W-1]}}, op};
  assign coef_ext = {{OUT_W{coef[COEF_W-1]}}, coef};
  assign prod     = op_ext * coef_ext;
  assign acc_d    = neg ? (acc_q - ACC_W'(prod)) : (acc_q + ACC_W'(prod));

  assign v_d    = round_half_up(wide_t'(acc_q), COEF_FRAC);
  assign y_w    = saturate(v_d, OUT_W);
  assign y_d    = OUT_W'(y_w);
  assign code_d = OUT_W'(to_offset(y_w, OUT_W));
  assign sat_d  = (v_d != y_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      bank_q       <= 1'b0;
      acc_q        <= '0;
      for (int i = 0; i <= ORDER; i++) x_hist_q[i] <= '0;
      for (int i = 1; i <= ORDER; i++) y_hist_q[i] <= '0;
      out_code_q   <= CODE_MID;
      out_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush || flush_pend_q) begin
            for (int i = 0; i <= ORDER; i++) x_hist_q[i] <= '0;
            for (int i = 1; i <= ORDER; i++) y_hist_q[i] <= '0;
            out_code_q   <= CODE_MID;
            sat_q        <= 1'b0;
            flush_pend_q <= 1'b0;
          end else if (in_valid && in_ready) begin
            x_hist_q[0] <= x_in;
            bank_q      <= bank_sel;
            acc_q       <= '0;
            k_q         <= '0;
            state_q     <= S_MAC;
          end
        end
        S_MAC: begin
          if (flush) flush_pend_q <= 1'b1;
          acc_q <= acc_d;
          k_q   <= k_q + 3'd1;
          if (k_q == 3'(NC - 1)) state_q <= S_UPD;
        end
        S_UPD: begin
          if (flush) flush_pend_q <= 1'b1;
          for (int i = 1; i <= ORDER; i++) x_hist_q[i] <= x_hist_q[i-1];
          for (int i = 2; i <= ORDER; i++) y_hist_q[i] <= y_hist_q[i-1];
          y_hist_q[1] <= y_d;
          out_code_q  <= code_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: doc/dlf_iir_serial.md
Name: dlf_iir_serial

Overview:
Parametrised, time-multiplexed IIR digital loop filter for the ADPLL, order 1..3, sitting between the phase/ADC magnitude output and the DCO code input.
- One shared multiplier-accumulator evaluates all taps serially under an FSM.
- Adds over the fixed-coefficient filter: a valid/ready input handshake, two run-time-writable coefficient banks (acquisition/tracking), round-half-up, output saturation with flag, hold and flush.

Parameters:
IN_W, 8, input magnitude width (signed sample is IN_W+1 bits)
OUT_W, 10, output code width; must be >= IN_W+1
COEF_W, 20, signed coefficient width
COEF_FRAC, 18, coefficient fractional bits
ORDER, 3, filter order, legal 1..3
ACC_W, OUT_W+COEF_W+3, accumulator width (signed)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
in_mag  in  IN_W  unsigned magnitude
in_lead  in  1  1 = feedback leads (positive), 0 = ref leads (negative)
bank_sel  in  1  coefficient bank for the next accepted sample
hold  in  1  freeze: no new samples accepted
flush  in  1  clear filter state
coef_we  in  1  coefficient write strobe
coef_bank  in  1  bank written
coef_addr  in  3  0..ORDER = b0..bORDER, ORDER+1..2*ORDER = a1..aORDER
coef_wdata  in  COEF_W  signed coefficient, Q(COEF_W-COEF_FRAC).COEF_FRAC
coef_err  out  1  one-cycle pulse: write dropped
out_valid  out  1  one-cycle pulse: new out_code
out_code  out  OUT_W  offset-binary DCO code (signed y with MSB inverted)
sat_flag  out  1  last output was clipped

Behaviour:
- Reset (sync, rst=1 at posedge):
  - out_code = 2^(OUT_W-1); out_valid, sat_flag, coef_err = 0; in_ready = 0 while rst is high.
  - x/y histories = 0; FSM = IDLE.
  - Both banks: b0 = 2^COEF_FRAC (1.0), all other coefficients = 0, i.e. pass-through.
- Sign conversion: x = in_lead ? +in_mag : -in_mag, IN_W+1 bits signed.
- FSM IDLE -> MAC -> UPD -> IDLE.
  - IDLE: in_ready = !hold && !flush. On in_valid && in_ready: latch x, latch bank_sel as active bank, clear acc, k = 0, go to MAC.
  - MAC: exactly 2*ORDER+1 cycles, one product per cycle.
    - Terms k = 0..ORDER: acc += b_k * x_hist[k], where x_hist[0] is the new x.
    - Then k = 1..ORDER: acc -= a_k * y_hist[k].
  - UPD: one cycle, then back to IDLE. In this cycle:
    - v = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift, round half up).
    - y = saturate(v) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flag = (v != y).
    - Shift x and y histories; register out_code = {~y[MSB], y[rest]}.
- Timing:
  - out_valid is high in the cycle after UPD.
  - Accept at edge 0 -> out_valid at cycle 2*ORDER+3 (9 for ORDER=3).
  - Max rate is one sample per 2*ORDER+3 cycles; in_ready is low outside IDLE.
- Storage: y history is kept as the saturated OUT_W-bit value; acc never wraps by construction of ACC_W.
- hold:
  - Blocks new accepts only; a computation already in flight completes.
  - out_code is held while hold=1.
- flush:
  - Honoured only in IDLE: clears histories, out_code = 2^(OUT_W-1), sat_flag = 0. Coefficients are retained.
  - If flush is asserted while busy, it takes effect on the first IDLE cycle.
  - flush has priority over in_valid in the same cycle.
- Coefficient writes:
  - Write takes effect at the clock edge.
  - A write to the active bank while FSM != IDLE is dropped and coef_err pulses.
  - A write to the inactive bank is always accepted.
  - coef_addr > 2*ORDER: write dropped, coef_err pulses.
- rst mid-operation: computation is abandoned, no out_valid is produced, all state returns to reset values, in_ready = 1 in the first cycle after rst deasserts.

Decomposition:
- Package dlf_pkg:
  - FSM state enum (IDLE/MAC/UPD);
  - COEF_ONE = 2^COEF_FRAC;
  - address-map constants for b/a index;
  - saturate and round functions;
  - offset-binary conversion function.
- Sub-module dlf_coef_bank: 2 x (2*ORDER+1) coefficient register file with reset values, write port with error detection, and combinational read by (bank, index).

Test Plan (defaults, ORDER=3, OUT_W=10):
1. Reset pass-through: lead=1, mag=5 -> out_valid exactly 9 cycles after accept, out_code=517. Then lead=0, mag=5 -> 507. in_ready is low for cycles 1..8.
2. Integrator (bank0: b0=0x40000, a1=0xC0000 i.e. -1.0): four samples of +3 -> out_code 515, 518, 521, 524.
3. Saturation (integrator, lead=1, mag=255) -> y = 255, 510, 511. out_code = 767, 1022, 1023. sat_flag=1 only on the third output.
4. Rounding (b0=0x20000, 0.5):
   - +3 -> y=2 -> out_code 514.
   - -3 -> y=-1 -> out_code 511.
5. Bank/hold/flush/coef_err:
   - bank1 b0=0x30000; bank_sel=1, +4 -> out_code 515.
   - Writing bank1 during MAC -> coef_err pulse and coefficient unchanged.
   - hold=1 -> in_ready=0 and out_code stable.
   - flush -> out_code=512.
6. rst pulse during MAC cycle 4 -> no out_valid, out_code=512, in_ready=1 on the first cycle after release, coefficients back to pass-through.
